// File: rtl/mips_pkg.sv
// ============================================================================
//  mips_pkg : shared ALU function codes, sequencer states and MDU op codes.
//  Rev 1.0  - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

   localparam logic [3:0] ALUC_AND = 4'b0000;
   localparam logic [3:0] ALUC_OR  = 4'b0001;
   localparam logic [3:0] ALUC_ADD = 4'b0010;
   localparam logic [3:0] ALUC_XOR = 4'b0011;
   localparam logic [3:0] ALUC_NOR = 4'b0100;
   localparam logic [3:0] ALUC_SUB = 4'b0101;

   localparam logic OP_MULTU = 1'b0;
   localparam logic OP_DIVU  = 1'b1;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_RUN  = 2'd1,
      SEQ_DONE = 2'd2
   } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/mdu_step.sv
// ============================================================================
//  mdu_step : one-bit MULTU shift-add / DIVU restoring step, combinational.
//  Rev 1.0  - initial release
// ============================================================================
`default_nettype none

module mdu_step
   import mips_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            op,
   input  logic [XLEN-1:0] alu_res,
   input  logic [XLEN-1:0] pr,
   input  logic [XLEN-1:0] q,
   input  logic [XLEN-1:0] d,
   output logic [XLEN-1:0] pr_nxt,
   output logic [XLEN-1:0] q_nxt
);

   logic [XLEN-1:0] s;
   logic            carry;

   always_comb begin
      s      = {pr[XLEN-2:0], q[XLEN-1]};
      carry  = 1'b0;
      pr_nxt = pr;
      q_nxt  = q;
      if (op == OP_MULTU) begin
         if (q[0]) begin
            // carry out of P+M recovered from wraparound of the shared ALU
            carry  = (alu_res < pr);
            pr_nxt = {carry, alu_res[XLEN-1:1]};
            q_nxt  = {alu_res[0], q[XLEN-1:1]};
         end else begin
            pr_nxt = {1'b0, pr[XLEN-1:1]};
            q_nxt  = {pr[0], q[XLEN-1:1]};
         end
      end else begin
         if (pr[XLEN-1] || (s >= d)) begin
            pr_nxt = alu_res;
            q_nxt  = {q[XLEN-2:0], 1'b1};
         end else begin
            pr_nxt = s;
            q_nxt  = {q[XLEN-2:0], 1'b0};
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_mdu_seq.sv
// ============================================================================
//  alu_mdu_seq : multi-cycle MULTU/DIVU sequencer borrowing the EXE-stage ALU.
//  Optional MULTU early exit with macro MDU_EARLY_EXIT_EN.
//  Rev 1.0  - initial release
// ============================================================================
`default_nettype none

module alu_mdu_seq
   import mips_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int ITER = XLEN
) (
   input  logic            clk,
   input  logic            clrn,
   input  logic            start,
   input  logic            op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            alu_own,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      aluc,
   input  logic [XLEN-1:0] alu_res,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CW = $clog2(ITER + 1);

   seq_state_t      state;
   logic            op_r;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] pr;
   logic [XLEN-1:0] q;
   logic [XLEN-1:0] pr_nxt;
   logic [XLEN-1:0] q_nxt;
   logic [XLEN-1:0] pr_fin;
   logic [XLEN-1:0] q_fin;
   logic [XLEN-1:0] a_nxt;
   logic            last;

   // divisor / multiplicand lives in alu_b, held constant through RUN
   mdu_step #(.XLEN(XLEN)) u_step (
      .op      (op_r),
      .alu_res (alu_res),
      .pr      (pr),
      .q       (q),
      .d       (alu_b),
      .pr_nxt  (pr_nxt),
      .q_nxt   (q_nxt)
   );

`ifdef MDU_EARLY_EXIT_EN
   logic [XLEN-1:0]   rem_mask;
   logic [CW-1:0]     rem_cnt;
   logic [2*XLEN-1:0] pq_shf;
   logic              early;

   // after this step, multiplier bits still unshifted sit in q_nxt below rem_mask
   always_comb begin
      rem_mask = {XLEN{1'b1}} >> (32'(cnt) + 32'd1);
      rem_cnt  = CW'(ITER - 1) - cnt;
      pq_shf   = {pr_nxt, q_nxt} >> rem_cnt;
      early    = (op_r == OP_MULTU) && ((q_nxt & rem_mask) == '0);
      last     = early || (cnt == CW'(ITER - 1));
      pr_fin   = early ? pq_shf[2*XLEN-1:XLEN] : pr_nxt;
      q_fin    = early ? pq_shf[XLEN-1:0]      : q_nxt;
   end
`else
   always_comb begin
      last   = (cnt == CW'(ITER - 1));
      pr_fin = pr_nxt;
      q_fin  = q_nxt;
   end
`endif

   always_comb begin
      a_nxt = (op_r == OP_MULTU) ? pr_fin : {pr_fin[XLEN-2:0], q_fin[XLEN-1]};
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state   <= SEQ_IDLE;
         op_r    <= OP_MULTU;
         cnt     <= '0;
         pr      <= '0;
         q       <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         alu_own <= 1'b0;
         alu_a   <= '0;
         alu_b   <= '0;
         aluc    <= ALUC_AND;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            SEQ_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op_r    <= op;
                  cnt     <= '0;
                  pr      <= '0;
                  q       <= (op == OP_DIVU) ? src_a : src_b;
                  busy    <= 1'b1;
                  alu_own <= 1'b1;
                  alu_a   <= (op == OP_DIVU) ? {{(XLEN-1){1'b0}}, src_a[XLEN-1]} : '0;
                  alu_b   <= (op == OP_DIVU) ? src_b : src_a;
                  aluc    <= (op == OP_DIVU) ? ALUC_SUB : ALUC_ADD;
                  state   <= SEQ_RUN;
               end
            end
            SEQ_RUN: begin
               cnt <= cnt + 1'b1;
               pr  <= pr_fin;
               q   <= q_fin;
               if (last) begin
                  busy    <= 1'b0;
                  alu_own <= 1'b0;
                  done    <= 1'b1;
                  hi      <= pr_fin;
                  lo      <= q_fin;
                  state   <= SEQ_DONE;
               end else begin
                  alu_a   <= a_nxt;
               end
            end
            SEQ_DONE: begin
               done  <= 1'b0;
               state <= SEQ_IDLE;
            end
            default: state <= SEQ_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu_seq.sv
// ============================================================================
//  tb_alu_mdu_seq : bench for alu_mdu_seq with an attached ALU model.
//  Rev 1.0  - initial release
// ============================================================================
`default_nettype none

module tb_alu_mdu_seq;

   localparam int XLEN = 32;
   localparam int ITER = 32;

   logic            clk = 1'b0;
   logic            clrn = 1'b0;
   logic            start = 1'b0;
   logic            op = 1'b0;
   logic [XLEN-1:0] src_a = '0;
   logic [XLEN-1:0] src_b = '0;
   logic            alu_own;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [3:0]      aluc;
   logic [XLEN-1:0] alu_res;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   alu_mdu_seq #(.XLEN(XLEN), .ITER(ITER)) dut (
      .clk     (clk),
      .clrn    (clrn),
      .start   (start),
      .op      (op),
      .src_a   (src_a),
      .src_b   (src_b),
      .alu_own (alu_own),
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .aluc    (aluc),
      .alu_res (alu_res),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   // shared EXE-stage ALU
   always_comb begin
      case (aluc)
         4'b0000: alu_res = alu_a & alu_b;
         4'b0001: alu_res = alu_a | alu_b;
         4'b0010: alu_res = alu_a + alu_b;
         4'b0011: alu_res = alu_a ^ alu_b;
         4'b0100: alu_res = ~(alu_a | alu_b);
         4'b0101: alu_res = alu_a - alu_b;
         default: alu_res = '0;
      endcase
   end

   function automatic int exp_lat(input logic o, input logic [XLEN-1:0] b);
`ifdef MDU_EARLY_EXIT_EN
      if (o == 1'b0) begin
         int msb = 0;
         for (int i = 0; i < XLEN; i++) if (b[i]) msb = i;
         return msb + 2;
      end
`endif
      return ITER + 1;
   endfunction

   task automatic model(input logic o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        output logic [XLEN-1:0] eh, output logic [XLEN-1:0] el);
      logic [2*XLEN-1:0] p;
      if (o == 1'b0) begin
         p  = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
         eh = p[2*XLEN-1:XLEN];
         el = p[XLEN-1:0];
      end else if (b == '0) begin
         eh = a;
         el = '1;
      end else begin
         eh = a % b;
         el = a / b;
      end
   endtask

   task automatic run_op(input logic o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input string name);
      logic [XLEN-1:0] eh, el;
      int              cyc;
      int              want;
      bit              seen;
      model(o, a, b, eh, el);
      want  = exp_lat(o, b);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 1;
      n_checks++;
      if (busy !== 1'b1 || alu_own !== 1'b1) begin
         n_fail++;
         $display("FAIL %s busy_first_cycle: busy=%b alu_own=%b required 1/1", name, busy, alu_own);
      end
      seen = 0;
      while (cyc <= ITER + 4) begin
         if (done === 1'b1) begin
            seen = 1;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s timeout: no done within %0d cycles", name, ITER + 4);
      end else begin
         if (cyc != want) begin
            n_fail++;
            $display("FAIL %s latency: got %0d required %0d", name, cyc, want);
         end
         n_checks++;
         if (hi !== eh || lo !== el || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s result: hi=%h lo=%h busy=%b required hi=%h lo=%h busy=0",
                     name, hi, lo, busy, eh, el);
         end
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL %s done_pulse: done=%b required 0", name, done);
      end
   endtask

   task automatic test_reset();
      clrn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, done, alu_own} !== 3'b000 || hi !== '0 || lo !== '0 ||
          alu_a !== '0 || alu_b !== '0 || aluc !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b own=%b hi=%h lo=%h a=%h b=%h aluc=%h required all 0",
                  busy, done, alu_own, hi, lo, alu_a, alu_b, aluc);
      end
      @(negedge clk);
      clrn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      run_op(1'b0, 32'd3, 32'd5, "mul_3x5");
      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
      run_op(1'b1, 32'd100, 32'd7, "div_100_7");
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ov");
      run_op(1'b1, 32'd1234, 32'd0, "div_by_zero");
      run_op(1'b0, 32'd7, 32'd2, "mul_7x2");
      run_op(1'b0, 32'h1234_5678, 32'd0, "mul_by_zero");
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         logic [XLEN-1:0] a, b;
         a = $urandom;
         b = $urandom;
         if (i % 4 == 3) b = b >> $urandom_range(31, 16);
         run_op(i[0], a, b, "random");
      end
   endtask

   task automatic test_back_to_back();
      run_op(1'b1, 32'hDEAD_BEEF, 32'd13, "b2b_div");
      run_op(1'b0, 32'hDEAD_BEEF, 32'd13, "b2b_mul");
   endtask

   task automatic test_start_ignored();
      logic [XLEN-1:0] eh, el;
      int              pulses;
      int              cyc;
      logic [XLEN-1:0] cap_hi, cap_lo;
      model(1'b1, 32'd9999, 32'd77, eh, el);
      start = 1'b1; op = 1'b1; src_a = 32'd9999; src_b = 32'd77;
      @(posedge clk); #1;
      start  = 1'b0;
      pulses = 0;
      cap_hi = '0;
      cap_lo = '0;
      for (cyc = 1; cyc <= ITER + 12; cyc++) begin
         if (cyc == 10) begin
            start = 1'b1; op = 1'b0; src_a = 32'd5; src_b = 32'd6;
         end else begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            pulses++;
            cap_hi = hi;
            cap_lo = lo;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      n_checks++;
      if (pulses != 1 || cap_hi !== eh || cap_lo !== el) begin
         n_fail++;
         $display("FAIL start_ignored: pulses=%0d hi=%h lo=%h required 1 hi=%h lo=%h",
                  pulses, cap_hi, cap_lo, eh, el);
      end
   endtask

   task automatic test_reset_mid();
      start = 1'b1; op = 1'b0; src_a = 32'hABCD; src_b = 32'h1234;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #2;
      clrn = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, alu_own} !== 3'b000 || hi !== '0 || lo !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: busy=%b done=%b own=%b hi=%h lo=%h required all 0",
                  busy, done, alu_own, hi, lo);
      end
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: busy=%b done=%b required 0/0", busy, done);
      end
      @(negedge clk);
      clrn = 1'b1;
      @(posedge clk); #1;
      run_op(1'b1, 32'd100, 32'd7, "after_reset");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_start_ignored();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
